// File: rtl/serial_adder_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_n_pkg
// Description : Shared constants for the bit-serial adder: FSM state
//               encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_n_pkg;

    // Default operand/result width in bits
    localparam int c_DEFAULT_WIDTH = 8;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_RUN  = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

endpackage : serial_adder_n_pkg
`default_nettype wire

// File: rtl/serial_adder_n_fulladder.sv
`default_nettype none
// ============================================================================
// Module      : halfadder_n / fulladder_n
// Description : One-bit adder cell for the serial adder, built from two
//               half adders whose carries are ORed.
// Revision    : 1.0 - initial release
// ============================================================================
module halfadder_n (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule : halfadder_n

module fulladder_n (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    // First stage adds the operand bits, second stage folds in the carry
    halfadder_n u_ha0 (
        .x (a),
        .y (b),
        .s (w_s0),
        .c (w_c0)
    );

    halfadder_n u_ha1 (
        .x (w_s0),
        .y (ci),
        .s (s),
        .c (w_c1)
    );

    // At most one of the two half-adder carries can be set
    assign co = w_c0 | w_c1;

endmodule : fulladder_n
`default_nettype wire

// File: rtl/serial_adder_n.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_n
// Description : Bit-serial unsigned adder. Operands are captured on start,
//               added LSB-first through a single full-adder cell over WIDTH
//               cycles, and the result is published with a one-cycle done.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_n
    import serial_adder_n_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_res_next;
    // LSB of the result register only ever holds filler before the last shift
    logic             w_unused_res_lsb;

    fulladder_n u_cell (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_c),
        .s  (w_s),
        .co (w_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB
    assign w_res_next       = {w_s, r_res[WIDTH-1:1]};
    assign w_unused_res_lsb = r_res[0];

    // Control FSM, datapath shifting and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            carry   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= cin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_c   <= w_co;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        sum     <= w_res_next;
                        carry   <= w_co;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule : serial_adder_n
`default_nettype wire
